// File: rtl/biquad8_zero_coeff_loader.sv
// rtl/biquad8_zero_coeff_loader.sv - shadow-register coefficient sequencer for the biquad zero FIR stage
// Optional readback of applied coefficients: define BIQUAD_ZERO_COEFF_READBACK_EN.
module biquad8_zero_coeff_loader #(
    parameter int                    COEFF_BITS = 18,
    parameter int                    WR_SPACING = 1,
    parameter logic [COEFF_BITS-1:0] DEFAULT_B  = '0,
    parameter logic [COEFF_BITS-1:0] DEFAULT_A  = '0,
    parameter bit                    AUTOLOAD   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_i,
    input  logic [1:0]            addr_i,
    input  logic [COEFF_BITS-1:0] dat_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [COEFF_BITS-1:0] coeff_dat_o,
    output logic                  coeff_wr_o,
    output logic                  coeff_update_o
`ifdef BIQUAD_ZERO_COEFF_READBACK_EN
    ,
    output logic [2*COEFF_BITS-1:0] rd_dat_o
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR_B = 3'd1,
        GAP1 = 3'd2,
        WR_A = 3'd3,
        GAP2 = 3'd4,
        UPD  = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(WR_SPACING - 1);
    localparam bit         HAS_GAP  = (WR_SPACING > 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    pending_q, pending_d;
    logic [COEFF_BITS-1:0]   b_sh_q, b_sh_d, a_sh_q, a_sh_d;
    logic [COEFF_BITS-1:0]   b_lat_q, b_lat_d, a_lat_q, a_lat_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    coeff_wr_q, coeff_wr_d;
    logic                    coeff_update_q, coeff_update_d;
    logic [COEFF_BITS-1:0]   coeff_dat_q, coeff_dat_d;
    logic                    commit;
    logic                    start;
`ifdef BIQUAD_ZERO_COEFF_READBACK_EN
    logic [COEFF_BITS-1:0]   b_act_q, b_act_d, a_act_q, a_act_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        b_sh_d    = b_sh_q;
        a_sh_d    = a_sh_q;
        b_lat_d   = b_lat_q;
        a_lat_d   = a_lat_q;
        start     = 1'b0;
        commit    = wr_i && (addr_i == 2'd2);

        if (wr_i && (addr_i == 2'd0)) b_sh_d = dat_i;
        if (wr_i && (addr_i == 2'd1)) a_sh_d = dat_i;

        case (state_q)
            IDLE: if (commit || pending_q) start = 1'b1;
            WR_B: begin
                if (HAS_GAP) begin
                    state_d = GAP1;
                    cnt_d   = GAP_LOAD;
                end else begin
                    state_d = WR_A;
                end
            end
            GAP1: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = WR_A;
            end
            WR_A: begin
                if (HAS_GAP) begin
                    state_d = GAP2;
                    cnt_d   = GAP_LOAD;
                end else begin
                    state_d = UPD;
                end
            end
            GAP2: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = UPD;
            end
            UPD:  state_d = DONE;
            DONE: begin
                if (commit || pending_q) start = 1'b1;
                else                     state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A fresh latch per sequence keeps mid-sequence shadow writes out of the FIR.
        if (start) begin
            state_d   = WR_B;
            b_lat_d   = b_sh_q;
            a_lat_d   = a_sh_q;
            pending_d = 1'b0;
        end else if (commit) begin
            pending_d = 1'b1;
        end

        busy_d         = (state_d != IDLE);
        done_d         = (state_d == DONE);
        coeff_update_d = (state_d == UPD);
        coeff_wr_d     = (state_d == WR_B) || (state_d == WR_A);
        coeff_dat_d    = '0;
        if (state_d == WR_B) coeff_dat_d = b_lat_d;
        if (state_d == WR_A) coeff_dat_d = a_lat_d;

`ifdef BIQUAD_ZERO_COEFF_READBACK_EN
        b_act_d = b_act_q;
        a_act_d = a_act_q;
        if (state_q == UPD) begin
            b_act_d = b_lat_q;
            a_act_d = a_lat_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            pending_q      <= AUTOLOAD;
            b_sh_q         <= DEFAULT_B;
            a_sh_q         <= DEFAULT_A;
            b_lat_q        <= '0;
            a_lat_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            coeff_wr_q     <= 1'b0;
            coeff_update_q <= 1'b0;
            coeff_dat_q    <= '0;
`ifdef BIQUAD_ZERO_COEFF_READBACK_EN
            b_act_q        <= '0;
            a_act_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pending_q      <= pending_d;
            b_sh_q         <= b_sh_d;
            a_sh_q         <= a_sh_d;
            b_lat_q        <= b_lat_d;
            a_lat_q        <= a_lat_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            coeff_wr_q     <= coeff_wr_d;
            coeff_update_q <= coeff_update_d;
            coeff_dat_q    <= coeff_dat_d;
`ifdef BIQUAD_ZERO_COEFF_READBACK_EN
            b_act_q        <= b_act_d;
            a_act_q        <= a_act_d;
`endif
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign coeff_wr_o     = coeff_wr_q;
    assign coeff_update_o = coeff_update_q;
    assign coeff_dat_o    = coeff_dat_q;
`ifdef BIQUAD_ZERO_COEFF_READBACK_EN
    assign rd_dat_o       = {a_act_q, b_act_q};
`endif

endmodule

// File: tb/tb_biquad8_zero_coeff_loader.sv
// tb/tb_biquad8_zero_coeff_loader.sv - scoreboard bench for biquad8_zero_coeff_loader
// Instance 0: WR_SPACING=1, AUTOLOAD with defaults; instance 1: WR_SPACING=3.
module tb_biquad8_zero_coeff_loader;
    localparam int CB = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic          rst_n [2];
    logic          wr    [2];
    logic [1:0]    addr  [2];
    logic [CB-1:0] dat   [2];
    logic          busy  [2];
    logic          done  [2];
    logic          cw    [2];
    logic          cu    [2];
    logic [CB-1:0] cd    [2];
`ifdef BIQUAD_ZERO_COEFF_READBACK_EN
    logic [2*CB-1:0] rd_dat0;
    logic [2*CB-1:0] rd_dat1;
`endif

    biquad8_zero_coeff_loader #(
        .COEFF_BITS(CB), .WR_SPACING(1),
        .DEFAULT_B(18'h00100), .DEFAULT_A(18'h04000), .AUTOLOAD(1'b1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .wr_i(wr[0]), .addr_i(addr[0]), .dat_i(dat[0]),
        .busy_o(busy[0]), .done_o(done[0]), .coeff_dat_o(cd[0]),
        .coeff_wr_o(cw[0]), .coeff_update_o(cu[0])
`ifdef BIQUAD_ZERO_COEFF_READBACK_EN
        , .rd_dat_o(rd_dat0)
`endif
    );

    biquad8_zero_coeff_loader #(
        .COEFF_BITS(CB), .WR_SPACING(3),
        .DEFAULT_B(18'h00000), .DEFAULT_A(18'h00000), .AUTOLOAD(1'b0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .wr_i(wr[1]), .addr_i(addr[1]), .dat_i(dat[1]),
        .busy_o(busy[1]), .done_o(done[1]), .coeff_dat_o(cd[1]),
        .coeff_wr_o(cw[1]), .coeff_update_o(cu[1])
`ifdef BIQUAD_ZERO_COEFF_READBACK_EN
        , .rd_dat_o(rd_dat1)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // kind: 0 = coefficient write, 1 = update strobe, 2 = done pulse
    typedef struct {
        int          cyc;
        int          kind;
        logic [CB-1:0] dat;
    } ev_t;

    ev_t exp_q [2][$];
    int  upd_cnt [2];

    task automatic push(input int id, input int c, input int kind, input logic [CB-1:0] d);
        ev_t e;
        e.cyc  = c;
        e.kind = kind;
        e.dat  = d;
        exp_q[id].push_back(e);
    endtask

    task automatic push_seq(input int id, input int k, input int s,
                            input logic [CB-1:0] b, input logic [CB-1:0] a);
        push(id, k,         0, b);
        push(id, k + s,     0, a);
        push(id, k + 2*s,   1, '0);
        push(id, k + 2*s+1, 2, '0);
    endtask

    task automatic mon(input int id);
        ev_t e;
        int  kind;
        chk($sformatf("wr_upd_excl%0d", id), 64'(cw[id] & cu[id]), 64'd0);
        if (!cw[id]) chk($sformatf("dat_idle%0d", id), 64'(cd[id]), 64'd0);
        while (exp_q[id].size() > 0 && exp_q[id][0].cyc < cyc) begin
            chk($sformatf("ev_missed%0d", id), 64'(exp_q[id][0].cyc), 64'(cyc));
            void'(exp_q[id].pop_front());
        end
        if (cu[id]) upd_cnt[id]++;
        if (cw[id] || cu[id] || done[id]) begin
            chk($sformatf("ev_expected%0d", id), 64'(exp_q[id].size() > 0), 64'd1);
            if (exp_q[id].size() > 0) begin
                e    = exp_q[id].pop_front();
                kind = cw[id] ? 0 : (cu[id] ? 1 : 2);
                chk($sformatf("ev_cyc%0d", id),  64'(cyc),  64'(e.cyc));
                chk($sformatf("ev_kind%0d", id), 64'(kind), 64'(e.kind));
                chk($sformatf("ev_dat%0d", id),  64'(cw[id] ? cd[id] : '0), 64'(e.dat));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Called at a falling edge; returns at the next falling edge with wr dropped.
    task automatic wr_reg(input int id, input logic [1:0] a, input logic [CB-1:0] d);
        wr[id]   = 1'b1;
        addr[id] = a;
        dat[id]  = d;
        @(negedge clk);
        wr[id]   = 1'b0;
    endtask

    task automatic chk_quiet(input int id, input string tag);
        chk({tag, "_busy"}, 64'(busy[id]), 64'd0);
        chk({tag, "_done"}, 64'(done[id]), 64'd0);
        chk({tag, "_wr"},   64'(cw[id]),   64'd0);
        chk({tag, "_upd"},  64'(cu[id]),   64'd0);
        chk({tag, "_dat"},  64'(cd[id]),   64'd0);
    endtask

    task automatic run_seq(input int id, input int s, input logic [CB-1:0] b, input logic [CB-1:0] a);
        int k;
        wr_reg(id, 2'd0, b);
        wr_reg(id, 2'd1, a);
        k = cyc + 1;
        push_seq(id, k, s, b, a);
        wr[id]   = 1'b1;
        addr[id] = 2'd2;
        dat[id]  = 18'h2AAAA;
        for (int i = 0; i <= 2*s + 2; i++) begin
            @(negedge clk);
            wr[id] = 1'b0;
            chk($sformatf("busy%0d_c%0d", id, i + 1), 64'(busy[id]), 64'(i <= 2*s + 1));
`ifdef BIQUAD_ZERO_COEFF_READBACK_EN
            if (id == 0 && i == 2*s + 1) chk("rd_dat_done", 64'(rd_dat0), 64'({a, b}));
`endif
        end
        chk($sformatf("q_empty%0d", id), 64'(exp_q[id].size()), 64'd0);
    endtask

    initial begin
        int k;
        int u;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; wr[i] = 1'b0; addr[i] = 2'd0; dat[i] = '0; upd_cnt[i] = 0;
        end
        repeat (2) @(negedge clk);
        chk_quiet(0, "rst0");
        chk_quiet(1, "rst1");

        // Autoload: defaults go out with no register activity.
        push_seq(0, cyc + 1, 1, 18'h00100, 18'h04000);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        repeat (6) @(negedge clk);
        chk("autoload_q_empty", 64'(exp_q[0].size()), 64'd0);
        chk("autoload_upd_cnt", 64'(upd_cnt[0]), 64'd1);
        chk("no_autoload_busy1", 64'(busy[1]), 64'd0);

        run_seq(0, 1, 18'h01234, 18'h00ABC);
        run_seq(1, 3, 18'h01234, 18'h00ABC);

        // Commits while busy collapse; mid-sequence shadow write only reaches the second run.
        u = upd_cnt[0];
        k = cyc + 1;
        push_seq(0, k,     1, 18'h01234, 18'h00ABC);
        push_seq(0, k + 4, 1, 18'h3FFFF, 18'h00ABC);
        wr_reg(0, 2'd2, '0);
        wr_reg(0, 2'd2, '0);
        wr_reg(0, 2'd0, 18'h3FFFF);
        wr_reg(0, 2'd2, '0);
        repeat (6) @(negedge clk);
        chk("pend_q_empty", 64'(exp_q[0].size()), 64'd0);
        chk("pend_two_updates", 64'(upd_cnt[0] - u), 64'd2);

        // Commit landing in the DONE cycle restarts immediately (S=3).
        k = cyc + 1;
        push_seq(1, k,     3, 18'h01234, 18'h00ABC);
        push_seq(1, k + 8, 3, 18'h01234, 18'h00ABC);
        wr_reg(1, 2'd2, '0);
        repeat (7) @(negedge clk);
        chk("done_cycle_done1", 64'(done[1]), 64'd1);
        wr_reg(1, 2'd2, '0);
        repeat (8) @(negedge clk);
        chk("done_commit_q_empty", 64'(exp_q[1].size()), 64'd0);

        // Reset during WR_A aborts without an update strobe.
        k = cyc + 1;
        push(1, k,     0, 18'h01234);
        push(1, k + 3, 0, 18'h00ABC);
        wr_reg(1, 2'd2, '0);
        repeat (3) @(negedge clk);
        chk("in_wr_a", 64'(cw[1]), 64'd1);
        #2 rst_n[1] = 1'b0;
        #1 chk_quiet(1, "abort");
        exp_q[1].delete();
        u = upd_cnt[1];
        @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_update", 64'(upd_cnt[1] - u), 64'd0);
        chk("abort_idle_busy", 64'(busy[1]), 64'd0);
        run_seq(1, 3, 18'h00055, 18'h3FF00);

`ifdef BIQUAD_ZERO_COEFF_READBACK_EN
        run_seq(0, 1, 18'h01234, 18'h00ABC);
        wr_reg(0, 2'd0, 18'h11111);
        repeat (2) @(negedge clk);
        chk("rd_dat_hold", 64'(rd_dat0), 64'({18'h00ABC, 18'h01234}));
        chk("rd_dat1", 64'(rd_dat1), 64'({18'h3FF00, 18'h00055}));
`endif

        repeat (2) @(negedge clk);
        chk("final_q0", 64'(exp_q[0].size()), 64'd0);
        chk("final_q1", 64'(exp_q[1].size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/biquad8_zero_coeff_loader.md
# biquad8_zero_coeff_loader

- Sequences coefficient loading into the biquad zero (numerator) FIR stage; sits directly upstream of that stage's coefficient port.
- Accepts register writes into shadow b/a registers. On commit, drives the FIR's fixed write protocol: b (z^-1 coeff), then a (z^0/z^-2 coeff), then one update strobe.
- Guarantees ordering, spacing, and atomicity, so software never drives the cascade-loaded DSP coefficients directly.

## Interface
Parameters:
- COEFF_BITS, 18, coefficient width (Q4.14).
- WR_SPACING, 1, clock cycles between successive strobes to the FIR; legal range 1..15.
- DEFAULT_B, 18'h00000, shadow b value after reset.
- DEFAULT_A, 18'h00000, shadow a value after reset.
- AUTOLOAD, 0, if 1, a commit is pending out of reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_i  in  1  register write strobe.
- addr_i  in  2  0 = shadow b, 1 = shadow a, 2 = commit, 3 = ignored.
- dat_i  in  COEFF_BITS  write data; ignored for commit.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse after update is issued.
- coeff_dat_o  out  COEFF_BITS  coefficient to FIR.
- coeff_wr_o  out  1  FIR coefficient write strobe.
- coeff_update_o  out  1  FIR update strobe.

## Operation
- Shadow registers b_sh and a_sh are written on wr_i with addr_i 0 or 1, in any state.
- Commit (wr_i with addr_i = 2):
  - If IDLE: latch b_sh and a_sh into b_lat and a_lat, then start the sequence.
  - If busy: set the pending flag. Multiple commits while busy collapse into one.
- Latched copies isolate the running sequence from shadow writes made mid-sequence.
- FSM states and transitions:
  - IDLE -> WR_B on commit or pending.
  - WR_B: coeff_wr_o = 1, coeff_dat_o = b_lat. Then GAP1 if WR_SPACING > 1, else WR_A.
  - GAP1: hold for WR_SPACING-1 cycles, then WR_A.
  - WR_A: coeff_wr_o = 1, coeff_dat_o = a_lat. Then GAP2 if WR_SPACING > 1, else UPD.
  - GAP2: hold for WR_SPACING-1 cycles, then UPD.
  - UPD: coeff_update_o = 1. Then DONE.
  - DONE: done_o = 1. Then WR_B if pending (pending cleared, fresh latch taken), else IDLE.
- coeff_dat_o is 0 whenever coeff_wr_o is low.
- coeff_wr_o and coeff_update_o are never high in the same cycle.
- Spacing counter: 4 bits, loaded with WR_SPACING-1 on entering a GAP state, decremented each cycle.
- A commit arriving in the DONE cycle sets pending and is honoured immediately.

## Timing
- All outputs are registered.
- Reset values: busy_o 0, done_o 0, coeff_dat_o 0, coeff_wr_o 0, coeff_update_o 0; FSM IDLE; b_sh = DEFAULT_B, a_sh = DEFAULT_A; pending = AUTOLOAD.
- Commit accepted at cycle 0 (S = WR_SPACING):
  - cycle 1: b written.
  - cycle 1+S: a written.
  - cycle 1+2S: update.
  - cycle 2+2S: done_o.
- busy_o is high from cycle 1 through cycle 2+2S inclusive.
- Back-to-back re-sequence from pending: next b write at cycle 3+2S.
- AUTOLOAD=1: first b write occurs 1 cycle after the first clock edge with rst_n high.
- Reset asserted mid-sequence: outputs clear asynchronously, sequence aborts, pending returns to AUTOLOAD.
  - The FIR may hold a partially shifted coefficient pair; the next full sequence restores consistency.

## Configuration
- BIQUAD_ZERO_COEFF_READBACK_EN defined:
  - Adds output rd_dat_o [2*COEFF_BITS-1:0] = {a_act, b_act}.
  - a_act and b_act are the values most recently applied by an update strobe.
  - They are registered on the UPD cycle, visible from the DONE cycle, and reset to 0.
- Macro undefined: rd_dat_o and its registers do not exist.

## Test plan
- WR_SPACING=1: write b=18'h01234 and a=18'h00ABC, commit at cycle 0 -> coeff_wr_o with 01234 at cycle 1, 00ABC at cycle 2; update at 3; done_o at 4; busy_o high cycles 1–4.
- WR_SPACING=3, same stimulus -> writes at cycles 1 and 4, update at 7, done_o at 8; coeff_dat_o = 0 in cycles 2, 3, 5, 6.
- Commit at cycle 0, write b=18'h3FFFF at cycle 2, commit again at cycle 2 -> first sequence still emits 01234. Second sequence starts right after done_o (S=1: b write at cycle 5 = 3FFFF, update at 7); exactly two update strobes total.
- AUTOLOAD=1 with DEFAULT_B=18'h00100, DEFAULT_A=18'h04000 -> after reset release, writes 00100 then 04000, then update, with no bus activity.
- Assert rst_n low during WR_A -> all outputs 0 within the same cycle, no update strobe; new commit after release runs a full, correct sequence.
- With the macro defined, after a sequence with b=01234 and a=00ABC -> rd_dat_o = {00ABC, 01234} from the done_o cycle. A later shadow write without commit leaves rd_dat_o unchanged.
